// File: rtl/mc_data_path_if.sv
// Memory request/response bus between the multi-cycle datapath and its memory.
// The datapath drives the request side; the memory answers with mem_ready/mem_rdata.
interface mc_data_path_if #(
  parameter int DW = 16,
  parameter int AW = 13
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_data_path.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB sequencing, register file, ALU
// and PC logic; control strobes come from an external controller.
module mc_data_path #(
  parameter int DW   = 16,
  parameter int AW   = 13,
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump,
  input  logic                     branch,
  input  logic                     jr,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     alu_src,
  input  logic                     reg_write,
  input  logic [1:0]               reg_dst,
  input  logic [1:0]               mem_to_reg,
  input  logic [2:0]               alu_ctl,
  mc_data_path_if.master           bus,
  output logic [2:0]               op,
  output logic [DW-1:0]            current_instr,
  output logic [AW-1:0]            current_pc,
  output logic [2:0]               state,
  output logic                     instr_done,
  input  logic [$clog2(NREG)-1:0]  dbg_sel,
  output logic [DW-1:0]            dbg_data
);
  localparam int LW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] npc_reg;
  logic [DW-1:0] ir_reg;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] alu_out_reg;
  logic [DW-1:0] mdr_reg;
  logic [DW-1:0] rf [NREG];

  logic [DW-1:0] op2;
  logic [3:0]    shamt;
  logic [DW-1:0] alu_f;
  logic          zero;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] br_target;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] npc_comb;
  logic          wb_needed;
  logic          mem_needed;
  logic          retire;
  logic [LW-1:0] wr_idx;
  logic [DW-1:0] wb_data;

  assign op2   = alu_src ? DW'(ir_reg[6:0]) : b_reg;
  assign shamt = op2[3:0];

  always_comb begin
    alu_f = '0;
    case (alu_ctl)
      3'b000: alu_f = a_reg + op2;
      3'b001: alu_f = a_reg - op2;
      3'b010: alu_f = a_reg & op2;
      3'b011: alu_f = a_reg | op2;
      3'b100: alu_f = DW'(a_reg < op2);
      3'b101: alu_f = a_reg ^ op2;
      3'b110: alu_f = a_reg << shamt;
      3'b111: alu_f = a_reg >> shamt;
      default: alu_f = '0;
    endcase
  end

  assign zero        = (alu_f == '0);
  assign pc_inc      = pc_reg + AW'(1);
  assign br_target   = pc_inc + AW'(ir_reg[6:0]);
  assign jump_target = AW'(ir_reg[12:0]);

  always_comb begin
    npc_comb = pc_inc;
    if (jr)
      npc_comb = a_reg[AW-1:0];
    else if (jump)
      npc_comb = jump_target;
    else if (branch && zero)
      npc_comb = br_target;
  end

  // jr never writes a register, so it also never visits WB.
  assign wb_needed  = reg_write && !jr;
  assign mem_needed = mem_read || mem_write;
  assign retire     = ((state_reg == S_EXEC) && !mem_needed && !wb_needed) ||
                      ((state_reg == S_MEM) && bus.mem_ready && !wb_needed) ||
                      (state_reg == S_WB);

  always_comb begin
    case (reg_dst)
      2'd0:    wr_idx = LW'(ir_reg[9:7]);
      2'd1:    wr_idx = LW'(ir_reg[6:4]);
      default: wr_idx = LW'(NREG - 1);
    endcase
    case (mem_to_reg)
      2'd0:    wb_data = alu_out_reg;
      2'd1:    wb_data = mdr_reg;
      default: wb_data = DW'(pc_inc);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_FETCH;
      pc_reg      <= '0;
      npc_reg     <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir_reg    <= bus.mem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg     <= rf[LW'(ir_reg[12:10])];
          b_reg     <= rf[LW'(ir_reg[9:7])];
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          alu_out_reg <= alu_f;
          npc_reg     <= npc_comb;
          if (mem_needed) begin
            state_reg <= S_MEM;
          end else if (wb_needed) begin
            state_reg <= S_WB;
          end else begin
            pc_reg    <= npc_comb;
            state_reg <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            mdr_reg <= bus.mem_rdata;
            if (wb_needed) begin
              state_reg <= S_WB;
            end else begin
              pc_reg    <= npc_reg;
              state_reg <= S_FETCH;
            end
          end
        end
        S_WB: begin
          pc_reg    <= npc_reg;
          state_reg <= S_FETCH;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Register 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if ((state_reg == S_WB) && (wr_idx != '0)) begin
      rf[wr_idx] <= wb_data;
    end
  end

  // Request lines decode from state but are also gated by rst so a reset
  // mid-access drops the request without waiting for a clock.
  assign bus.mem_req   = rst && ((state_reg == S_FETCH) || (state_reg == S_MEM));
  assign bus.mem_we    = rst && (state_reg == S_MEM) && mem_write;
  assign bus.mem_addr  = (state_reg == S_MEM) ? alu_out_reg[AW-1:0] : pc_reg;
  assign bus.mem_wdata = b_reg;

  assign op            = ir_reg[15:13];
  assign current_instr = ir_reg;
  assign current_pc    = pc_reg;
  assign state         = state_reg;
  assign instr_done    = retire;
  assign dbg_data      = (dbg_sel == '0) ? '0 : rf[dbg_sel];
endmodule

// File: tb/tb_mc_data_path.sv
// Self-checking bench for mc_data_path: a vector table of instructions with
// expected PC/register/latency results, a memory model with wait states, and a reset-in-MEM sequence.
module tb_mc_data_path;
  localparam int DW   = 16;
  localparam int AW   = 13;
  localparam int NREG = 8;

  localparam logic [6:0] C_J   = 7'h40;
  localparam logic [6:0] C_B   = 7'h20;
  localparam logic [6:0] C_JR  = 7'h10;
  localparam logic [6:0] C_MR  = 7'h08;
  localparam logic [6:0] C_MW  = 7'h04;
  localparam logic [6:0] C_SRC = 7'h02;
  localparam logic [6:0] C_RW  = 7'h01;

  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR  = 3'd3;
  localparam logic [2:0] A_SLT = 3'd4, A_XOR = 3'd5, A_SHL = 3'd6, A_SHR = 3'd7;

  typedef struct {
    logic [15:0] instr;
    logic [6:0]  ctl;
    logic [1:0]  rdst;
    logic [1:0]  m2r;
    logic [2:0]  alu;
    int          dwait;
    logic [12:0] exp_pc;
    int          chk_reg;
    logic [15:0] exp_val;
    int          exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic jump, branch, jr, mem_read, mem_write, alu_src, reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic [2:0] alu_ctl;
  logic [2:0] op, state;
  logic [DW-1:0] current_instr, dbg_data;
  logic [AW-1:0] current_pc;
  logic instr_done;
  logic [2:0] dbg_sel;

  mc_data_path_if #(.DW(DW), .AW(AW)) bus ();

  mc_data_path #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .jump(jump), .branch(branch), .jr(jr), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_ctl(alu_ctl), .bus(bus), .op(op), .current_instr(current_instr),
    .current_pc(current_pc), .state(state), .instr_done(instr_done),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Memory model: instruction array for fetches, small data array for MEM accesses.
  logic [DW-1:0] imem [0:(1<<AW)-1];
  logic [DW-1:0] dmem [0:255];
  int wait_cnt;
  int data_wait = 0;

  assign bus.mem_ready = bus.mem_req && (wait_cnt >= ((state == 3'd3) ? data_wait : 0));
  assign bus.mem_rdata = (state == 3'd3) ? dmem[bus.mem_addr[7:0]] : imem[bus.mem_addr];

  always @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 0;
      dmem[8'h31] <= 16'h0BAD;
    end else begin
      if (!bus.mem_req || bus.mem_ready) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      if (bus.mem_req && bus.mem_we && bus.mem_ready)
        dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  vec_t sb [$];
  vec_t tbl [26];
  logic [AW-1:0] pc_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [2:0] o, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [6:0] imm);
    return {o, rs, rt, imm};
  endfunction

  function automatic logic [15:0] ins_j(input logic [2:0] o, input logic [12:0] t);
    return {o, t};
  endfunction

  function automatic vec_t mkv(input logic [15:0] instr, input logic [6:0] c,
                               input logic [1:0] rd, input logic [1:0] m2r,
                               input logic [2:0] alu, input int w, input logic [12:0] pc,
                               input int r, input logic [15:0] val, input int cyc);
    vec_t v;
    v.instr = instr; v.ctl = c; v.rdst = rd; v.m2r = m2r; v.alu = alu; v.dwait = w;
    v.exp_pc = pc; v.chk_reg = r; v.exp_val = val; v.exp_cycles = cyc;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v, input logic [AW-1:0] pc_start);
    int cycles;
    logic timed_out, pc_ok, quiet_ok, hold_ok, have_ref;
    logic [2:0] got_op;
    logic [DW-1:0] got_ir;
    logic [AW+DW+1:0] ref_bus, cur_bus;
    vec_t e;
    imem[pc_start] = v.instr;
    {jump, branch, jr, mem_read, mem_write, alu_src, reg_write} = v.ctl;
    reg_dst = v.rdst; mem_to_reg = v.m2r; alu_ctl = v.alu; data_wait = v.dwait;
    sb.push_back(v);
    cycles = 0; timed_out = 0; pc_ok = 1; quiet_ok = 1; hold_ok = 1; have_ref = 0;
    got_op = 'x; got_ir = 'x; ref_bus = '0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (current_pc !== pc_start) pc_ok = 0;
      if ((state == 3'd1 || state == 3'd2 || state == 3'd4) && bus.mem_req !== 1'b0) quiet_ok = 0;
      if (state == 3'd1) begin got_op = op; got_ir = current_instr; end
      if (state == 3'd3) begin
        cur_bus = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        if (!have_ref) begin ref_bus = cur_bus; have_ref = 1; end
        else if (cur_bus !== ref_bus) hold_ok = 0;
      end
      if (instr_done === 1'b1) break;
      if (cycles >= 64) begin timed_out = 1; break; end
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("v%0d timeout", idx), 32'(timed_out), 32'd0);
    chk($sformatf("v%0d cycles", idx), cycles, e.exp_cycles);
    chk($sformatf("v%0d next_pc", idx), 32'(current_pc), 32'(e.exp_pc));
    chk($sformatf("v%0d state_after", idx), 32'(state), 32'd0);
    chk($sformatf("v%0d done_pulse_width", idx), 32'(instr_done), 32'd0);
    chk($sformatf("v%0d pc_held", idx), 32'(pc_ok), 32'd1);
    chk($sformatf("v%0d req_idle", idx), 32'(quiet_ok), 32'd1);
    chk($sformatf("v%0d mem_hold", idx), 32'(hold_ok), 32'd1);
    chk($sformatf("v%0d op", idx), 32'(got_op), 32'(e.instr[15:13]));
    chk($sformatf("v%0d ir", idx), 32'(got_ir), 32'(e.instr));
    dbg_sel = e.chk_reg[2:0];
    #1;
    chk($sformatf("v%0d R%0d", idx, e.chk_reg), 32'(dbg_data), 32'(e.exp_val));
    $display("instr %0d: pc %0h -> %0h, %0d cycles, R%0d=%0h", idx, pc_start, current_pc,
             cycles, e.chk_reg, dbg_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    {jump, branch, jr, mem_read, mem_write, alu_src, reg_write} = '0;
    reg_dst = '0; mem_to_reg = '0; alu_ctl = '0; dbg_sel = '0;

    //               instr                       ctl                     rd m2r alu    w  next_pc  reg val       cyc
    tbl[0]  = mkv(ins(1,0,1,7'h05),  C_SRC|C_RW,              0, 0, A_ADD, 0, 13'd1,   1, 16'h0005, 4);
    tbl[1]  = mkv(ins(2,0,2,7'h7F),  C_SRC|C_RW,              0, 0, A_ADD, 0, 13'd2,   2, 16'h007F, 4);
    tbl[2]  = mkv(ins(3,2,1,7'h30),  C_RW,                    1, 0, A_SUB, 0, 13'd3,   3, 16'h007A, 4);
    tbl[3]  = mkv(ins(4,2,4,7'h0F),  C_SRC|C_RW,              0, 0, A_AND, 0, 13'd4,   4, 16'h000F, 4);
    tbl[4]  = mkv(ins(5,1,5,7'h48),  C_SRC|C_RW,              0, 0, A_OR,  0, 13'd5,   5, 16'h004D, 4);
    tbl[5]  = mkv(ins(6,1,2,7'h60),  C_RW,                    1, 0, A_SLT, 0, 13'd6,   6, 16'h0001, 4);
    tbl[6]  = mkv(ins(7,0,1,7'h40),  C_RW,                    1, 0, A_SUB, 0, 13'd7,   4, 16'hFFFB, 4);
    tbl[7]  = mkv(ins(0,1,1,7'h04),  C_B,                     0, 0, A_SUB, 0, 13'd12,  1, 16'h0005, 3);
    tbl[8]  = mkv(ins(1,1,2,7'h04),  C_B,                     0, 0, A_SUB, 0, 13'd13,  2, 16'h007F, 3);
    tbl[9]  = mkv(ins(2,4,5,7'h04),  C_SRC|C_RW,              0, 0, A_SHL, 0, 13'd14,  5, 16'hFFB0, 4);
    tbl[10] = mkv(ins(3,4,6,7'h13),  C_SRC|C_RW,              0, 0, A_SHR, 0, 13'd15,  6, 16'h1FFF, 4);
    tbl[11] = mkv(ins(4,1,4,7'h30),  C_RW,                    1, 0, A_SLT, 0, 13'd16,  3, 16'h0001, 4);
    tbl[12] = mkv(ins(5,4,3,7'h05),  C_SRC|C_RW,              0, 0, A_ADD, 0, 13'd17,  3, 16'h0000, 4);
    tbl[13] = mkv(ins(6,0,1,7'h10),  C_SRC|C_MW,              0, 0, A_ADD, 3, 13'd18,  1, 16'h0005, 7);
    tbl[14] = mkv(ins(7,0,2,7'h10),  C_SRC|C_MR|C_RW,         0, 1, A_ADD, 3, 13'd19,  2, 16'h0005, 8);
    tbl[15] = mkv(ins(0,0,6,7'h31),  C_SRC|C_MR|C_MW|C_RW,    1, 1, A_ADD, 0, 13'd20,  3, 16'h0BAD, 5);
    tbl[16] = mkv(ins_j(1,13'd3),    C_J|C_RW,                2, 2, A_ADD, 0, 13'd3,   7, 16'h0015, 4);
    tbl[17] = mkv(ins_j(2,13'd40),   C_J|C_RW,                2, 2, A_ADD, 0, 13'd40,  7, 16'h0004, 4);
    tbl[18] = mkv(ins(3,0,5,7'h12),  C_SRC|C_RW,              0, 0, A_ADD, 0, 13'd41,  5, 16'h0012, 4);
    tbl[19] = mkv(ins(4,5,5,7'h04),  C_SRC|C_RW,              0, 0, A_SHL, 0, 13'd42,  5, 16'h0120, 4);
    tbl[20] = mkv(ins(5,5,5,7'h03),  C_SRC|C_RW,              0, 0, A_OR,  0, 13'd43,  5, 16'h0123, 4);
    tbl[21] = mkv(ins(6,5,1,7'h00),  C_JR|C_J|C_RW,           0, 0, A_ADD, 0, 13'h123, 1, 16'h0005, 3);
    tbl[22] = mkv(ins(7,0,0,7'h55),  C_SRC|C_RW,              0, 0, A_ADD, 0, 13'h124, 0, 16'h0000, 4);
    tbl[23] = mkv(ins_j(0,13'h1FFF), C_J,                     0, 0, A_ADD, 0, 13'h1FFF,7, 16'h0004, 3);
    tbl[24] = mkv(ins(1,1,1,7'h01),  C_SRC|C_RW,              0, 0, A_ADD, 0, 13'd0,   1, 16'h0006, 4);
    tbl[25] = mkv(ins(2,2,2,7'h7F),  C_SRC|C_RW,              0, 0, A_XOR, 0, 13'd1,   2, 16'h007A, 4);

    // Reset state
    #2;
    chk("reset state", 32'(state), 32'd0);
    chk("reset pc", 32'(current_pc), 32'd0);
    chk("reset ir", 32'(current_instr), 32'd0);
    chk("reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset instr_done", 32'(instr_done), 32'd0);
    for (int r = 0; r < NREG; r++) begin
      dbg_sel = 3'(r);
      #1;
      chk($sformatf("reset R%0d", r), 32'(dbg_data), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("first fetch req", 32'(bus.mem_req), 32'd1);
    chk("first fetch addr", 32'(bus.mem_addr), 32'd0);

    pc_model = '0;
    for (int i = 0; i < 26; i++) begin
      run_vec(i, tbl[i], pc_model);
      pc_model = tbl[i].exp_pc;
      if (i == 13) chk("store data @10", 32'(dmem[8'h10]), 32'h0005);
      if (i == 15) chk("store data @31", 32'(dmem[8'h31]), 32'h1FFF);
    end

    // Reset asserted while a load is stalled in MEM.
    imem[pc_model] = ins(0,0,2,7'h10);
    {jump, branch, jr, mem_read, mem_write, alu_src, reg_write} = C_SRC|C_MR|C_RW;
    reg_dst = 2'd0; mem_to_reg = 2'd1; alu_ctl = A_ADD; data_wait = 20;
    n = 0;
    while (state !== 3'd3 && n < 20) begin @(negedge clk); n++; end
    chk("rst_seq reached MEM", 32'(state), 32'd3);
    repeat (2) @(negedge clk);
    chk("rst_seq req while waiting", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_seq mem_req drop", 32'(bus.mem_req), 32'd0);
    chk("rst_seq state", 32'(state), 32'd0);
    chk("rst_seq pc", 32'(current_pc), 32'd0);
    chk("rst_seq ir", 32'(current_instr), 32'd0);
    dbg_sel = 3'd2;
    #1 chk("rst_seq R2", 32'(dbg_data), 32'd0);
    dbg_sel = 3'd7;
    #1 chk("rst_seq R7", 32'(dbg_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    data_wait = 0;
    #1;
    chk("rst_seq refetch req", 32'(bus.mem_req), 32'd1);
    chk("rst_seq refetch addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_seq refetch we", 32'(bus.mem_we), 32'd0);
    run_vec(99, mkv(ins(3,0,1,7'h05), C_SRC|C_RW, 0, 0, A_ADD, 0, 13'd1, 1, 16'h0005, 4), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_data_path.md
MC_DATA_PATH -- requirements
Module: mc_data_path

Interface
REQ-001 Parameter DW, default 16, datapath and register width; SHALL be at least 16.
REQ-002 Parameter AW, default 13, PC and memory address width; SHALL be at most DW.
REQ-003 Parameter NREG, default 8, register count; SHALL be a power of 2, at least 8.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 jump, branch, jr, mem_read, mem_write, alu_src, reg_write  in  1 each  control strobes from the external controller.
REQ-007 reg_dst, mem_to_reg  in  2 each  write-register and write-data selects.
REQ-008 alu_ctl  in  3  ALU operation select.
REQ-009 mem_req  out  1  memory access request.
REQ-010 mem_we  out  1  write qualifier for mem_req.
REQ-011 mem_addr  out  AW  access address.
REQ-012 mem_wdata  out  DW  store data.
REQ-013 mem_rdata  in  DW  load/fetch data, valid in the mem_ready cycle.
REQ-014 mem_ready  in  1  completes the current request.
REQ-015 op  out  3  instruction bits [15:13] of IR.
REQ-016 current_instr  out  DW  instruction register IR.
REQ-017 current_pc  out  AW  PC of the instruction in flight.
REQ-018 state  out  3  FSM state code.
REQ-019 instr_done  out  1  one-cycle pulse at instruction retirement.
REQ-020 dbg_sel  in  log2(NREG)  register index; dbg_data  out  DW  combinational read of that register.

Function
REQ-021 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-022 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready, IR<=mem_rdata and state<=DECODE; otherwise hold.
REQ-023 DECODE: A<=R[IR[12:10]], B<=R[IR[9:7]]; always exactly 1 cycle; control inputs SHALL be valid from this cycle until retirement.
REQ-024 EXEC: ALUOut<=f(A, alu_src ? zero-extended IR[6:0] : B); zero flag = (f==0); 1 cycle.
REQ-025 alu_ctl: 000 add, 001 sub, 010 and, 011 or, 100 unsigned slt (result 1/0), 101 xor, 110 shl by operand2[3:0], 111 logical shr by operand2[3:0]; results modulo 2^DW.
REQ-026 Next PC, resolved in EXEC; priority jr > jump > taken branch > sequential: jr -> A[AW-1:0]; jump -> IR[12:0] zero-extended or truncated to AW; branch & zero -> PC+1+IR[6:0]; else PC+1; all modulo 2^AW.
REQ-027 PC SHALL update only at retirement; current_pc stays constant through the instruction.
REQ-028 After EXEC: mem_read|mem_write -> MEM; else reg_write & !jr -> WB; else retire, go to FETCH.
REQ-029 MEM: mem_req=1, mem_addr=ALUOut[AW-1:0], mem_we=mem_write, mem_wdata=B; on mem_ready, MDR<=mem_rdata; then WB if reg_write & !jr, else retire.
REQ-030 mem_read and mem_write both set: the access SHALL be a write; MDR is still loaded.
REQ-031 While mem_ready=0, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable.
REQ-032 mem_req SHALL be 0 in DECODE, EXEC and WB.
REQ-033 WB: destination = reg_dst 0 -> IR[9:7], 1 -> IR[6:4], 2/3 -> NREG-1; data = mem_to_reg 0 -> ALUOut, 1 -> MDR, 2/3 -> zero-extended PC+1; then retire.
REQ-034 Register 0 SHALL read 0; writes to it are discarded.
REQ-035 jr SHALL suppress the register write regardless of reg_write.
REQ-036 Retirement: instr_done=1 for the cycle leaving the last state; PC<=next PC on the same edge.
REQ-037 Latency, zero-wait memory: ALU op 3 cycles, with WB 4, load 5, store 4; each mem_ready wait cycle adds 1.
REQ-038 At dbg_sel=0, dbg_data SHALL return 0.

Reset
REQ-039 rst=0 SHALL immediately set state=FETCH, PC=0, IR=A=B=ALUOut=MDR=0, all registers 0, mem_req=0, instr_done=0.
REQ-040 rst asserted mid-access SHALL drop mem_req asynchronously and abandon the instruction; no register or PC update.
REQ-041 First fetch SHALL request address 0 on the first clock edge after rst deasserts.

Verification
REQ-042 addi R1=R0+5 (alu_src=1, alu_ctl=000, reg_write, reg_dst=0), zero-wait -> R1=5 after 4 cycles; PC 0->1; one instr_done pulse.
REQ-043 Store R1 to address 0x10, then load it to R2, with mem_ready delayed 3 cycles each -> address and data held stable; R2=5; each instruction 3 cycles longer.
REQ-044 Branch with A=B (sub, zero=1), IR[6:0]=4 at PC=7 -> PC=12; with A!=B -> PC=8.
REQ-045 PC=2^AW-1, sequential instruction -> PC wraps to 0; jal (jump, reg_dst=2, mem_to_reg=2) at PC=3 -> R7=4.
REQ-046 jr with A=0x0123 and reg_write=1 -> PC=0x0123; no register changes; write to R0 -> dbg_data(0)=0.
REQ-047 rst pulse during MEM wait -> mem_req=0 immediately; PC and registers 0; fetch at address 0 resumes after release.
